// File: rtl/ex_mul_arb.sv
// ex_mul_arb: shares one 3-stage pipelined 32x32->64 multiplier between lanes A and B.
// Latency: accept at the end of cycle c -> result in cycle c+4 (c+5 with JX2_EXMULARB_SKID_EN).
// Backpressure: reqX_ready comes from arbitration/flush; base build ignores resX_ready, skid build credits a 2-entry FIFO.
//
// Ports: clock/reset (sync, active-high); reqA_*/reqB_* request lanes; flushA/flushB per-lane kill;
//        mulRs/mulRt/mulUIxt registered multiplier drive, mulRn product in; resA_*/resB_* result lanes.
// Optional feature macro: JX2_EXMULARB_SKID_EN (per-lane 2-entry result FIFO honouring resX_ready).
module ex_mul_arb #(
    parameter int TAG_W    = 5,
    parameter int FIX_PRIO = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqA_valid,
    output logic             reqA_ready,
    input  logic [31:0]      reqA_rs,
    input  logic [31:0]      reqA_rt,
    input  logic             reqA_uns,
    input  logic [TAG_W-1:0] reqA_tag,
    input  logic             reqB_valid,
    output logic             reqB_ready,
    input  logic [31:0]      reqB_rs,
    input  logic [31:0]      reqB_rt,
    input  logic             reqB_uns,
    input  logic [TAG_W-1:0] reqB_tag,
    input  logic             flushA,
    input  logic             flushB,
    output logic [31:0]      mulRs,
    output logic [31:0]      mulRt,
    output logic [7:0]       mulUIxt,
    input  logic [63:0]      mulRn,
    output logic             resA_valid,
    output logic [63:0]      resA_data,
    output logic [TAG_W-1:0] resA_tag,
    input  logic             resA_ready,
    output logic             resB_valid,
    output logic [63:0]      resB_data,
    output logic [TAG_W-1:0] resB_tag,
    input  logic             resB_ready
);
    localparam int NST = 4;  // shadow stages P1..P4

    // Shadow pipeline: index 0 = P1 ... index 3 = P4 (aligned with mulRn)
    logic [NST-1:0]   vld_q, vld_d;
    logic [NST-1:0]   lane_q, lane_d;  // 0 = lane A, 1 = lane B
    logic [TAG_W-1:0] tag_q [NST];
    logic [TAG_W-1:0] tag_d [NST];

    logic [31:0] rs_q, rs_d, rt_q, rt_d;
    logic        uns_q, uns_d;
    logic        prio_b_q, prio_b_d;  // 1: lane B wins the next tie

    logic [1:0] req_vld, flush_v, credit, elig;
    logic       gnt_a, gnt_b;

    assign req_vld = {reqB_valid, reqA_valid};
    assign flush_v = {flushB, flushA};

`ifdef JX2_EXMULARB_SKID_EN
    logic [1:0]       res_rdy_v, push, pop, res_vld;
    logic [2:0]       infl [2];
    logic [63:0]      fdat_q [2][2];
    logic [63:0]      fdat_d [2][2];
    logic [TAG_W-1:0] ftag_q [2][2];
    logic [TAG_W-1:0] ftag_d [2][2];
    logic [1:0]       fcnt_q [2];
    logic [1:0]       fcnt_d [2];
    logic             frp_q [2];
    logic             frp_d [2];

    assign res_rdy_v = {resB_ready, resA_ready};

    // A lane may only have as many ops outstanding as its FIFO can absorb.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            infl[l] = 3'd0;
            for (int i = 0; i < NST; i++) begin
                infl[l] = infl[l] + {2'b0, (vld_q[i] && (lane_q[i] == 1'(l)))};
            end
            credit[l] = (infl[l] + {1'b0, fcnt_q[l]}) < 3'd2;
        end
    end

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            res_vld[l] = (fcnt_q[l] != 2'd0) && !reset;
            pop[l]     = res_vld[l] && res_rdy_v[l];
            push[l]    = vld_q[3] && (lane_q[3] == 1'(l)) && !flush_v[l];
            frp_d[l]   = frp_q[l] ^ pop[l];
            for (int e = 0; e < 2; e++) begin
                fdat_d[l][e] = fdat_q[l][e];
                ftag_d[l][e] = ftag_q[l][e];
            end
            // Write slot is rd_ptr + count; count never exceeds 2 thanks to credits.
            if (push[l]) begin
                fdat_d[l][frp_q[l] ^ fcnt_q[l][0]] = mulRn;
                ftag_d[l][frp_q[l] ^ fcnt_q[l][0]] = tag_q[3];
            end
            fcnt_d[l] = fcnt_q[l] + 2'(push[l]) - 2'(pop[l]);
            if (flush_v[l]) begin
                fcnt_d[l] = 2'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int l = 0; l < 2; l++) begin
            if (reset) begin
                fcnt_q[l] <= 2'd0;
                frp_q[l]  <= 1'b0;
                for (int e = 0; e < 2; e++) begin
                    fdat_q[l][e] <= 64'd0;
                    ftag_q[l][e] <= '0;
                end
            end else begin
                fcnt_q[l] <= fcnt_d[l];
                frp_q[l]  <= frp_d[l];
                for (int e = 0; e < 2; e++) begin
                    fdat_q[l][e] <= fdat_d[l][e];
                    ftag_q[l][e] <= ftag_d[l][e];
                end
            end
        end
    end

    assign resA_valid = res_vld[0];
    assign resA_data  = fdat_q[0][frp_q[0]];
    assign resA_tag   = ftag_q[0][frp_q[0]];
    assign resB_valid = res_vld[1];
    assign resB_data  = fdat_q[1][frp_q[1]];
    assign resB_tag   = ftag_q[1][frp_q[1]];
`else
    logic unused_res_rdy;
    assign unused_res_rdy = &{1'b0, resA_ready, resB_ready};
    assign credit = 2'b11;

    // Bypass: P4 is aligned with the multiplier output, steer it straight out.
    assign resA_valid = vld_q[3] && !lane_q[3] && !reset;
    assign resA_data  = mulRn;
    assign resA_tag   = tag_q[3];
    assign resB_valid = vld_q[3] && lane_q[3] && !reset;
    assign resB_data  = mulRn;
    assign resB_tag   = tag_q[3];
`endif

    // Arbitration, issue register and shadow advance
    always_comb begin
        elig  = req_vld & ~flush_v & credit & {2{~reset}};
        gnt_a = elig[0] && (!elig[1] || (FIX_PRIO != 0) || !prio_b_q);
        gnt_b = elig[1] && !gnt_a;

        prio_b_d = prio_b_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        uns_d    = uns_q;
        if (gnt_a) begin
            prio_b_d = 1'b1;
            rs_d     = reqA_rs;
            rt_d     = reqA_rt;
            uns_d    = reqA_uns;
        end else if (gnt_b) begin
            prio_b_d = 1'b0;
            rs_d     = reqB_rs;
            rt_d     = reqB_rt;
            uns_d    = reqB_uns;
        end

        vld_d[0]  = gnt_a || gnt_b;
        lane_d[0] = gnt_b;
        tag_d[0]  = gnt_b ? reqB_tag : reqA_tag;
        // Flush kills entries as they advance, so P2..P4 never hold a flushed op.
        for (int i = 1; i < NST; i++) begin
            vld_d[i]  = vld_q[i-1] && !flush_v[lane_q[i-1]];
            lane_d[i] = lane_q[i-1];
            tag_d[i]  = tag_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q    <= '0;
            lane_q   <= '0;
            rs_q     <= 32'd0;
            rt_q     <= 32'd0;
            uns_q    <= 1'b0;
            prio_b_q <= 1'b0;
            for (int i = 0; i < NST; i++) tag_q[i] <= '0;
        end else begin
            vld_q    <= vld_d;
            lane_q   <= lane_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            uns_q    <= uns_d;
            prio_b_q <= prio_b_d;
            for (int i = 0; i < NST; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign reqA_ready = gnt_a;
    assign reqB_ready = gnt_b;
    assign mulRs      = rs_q;
    assign mulRt      = rt_q;
    assign mulUIxt    = {7'b0, uns_q};
endmodule
